// File: rtl/if_id_pkg.sv
// Shared widths, opcodes, instruction field positions and controller states
// for the fetch-side steering logic in the ID stage.
package if_id_pkg;

    localparam int IW = 20;
    localparam int AW = 8;

    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 12;
    localparam int RS1_MSB = 11;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/id_squash_counter.sv
// Saturating count of fetched slots thrown away by stalls, jumps and HALT.
module id_squash_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clkwire,
    input  logic             rstwire,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clkwire or posedge rstwire) begin
        if (rstwire) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_fetch_ctrl.sv
// IF/ID register plus the controller that steers fetch through its jump
// inputs: boot vector, unconditional jumps, stall replay and HALT parking.
import if_id_pkg::*;

module id_fetch_ctrl #(
    parameter int          IW           = if_id_pkg::IW,
    parameter int          AW           = if_id_pkg::AW,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter int          CNT_W        = 16
) (
    input  logic             clkwire,
    input  logic             rstwire,
    input  logic [IW-1:0]    instructionwire,
    input  logic [AW-1:0]    npc,
    input  logic             stall_in,
    output logic             jump_selector,
    output logic [AW-1:0]    jump_address,
    output logic             id_valid,
    output logic [IW-1:0]    id_instruction,
    output logic [AW-1:0]    id_pc,
    output logic [3:0]       id_opcode,
    output logic [3:0]       id_rd,
    output logic [3:0]       id_rs1,
    output logic [3:0]       id_rs2,
    output logic [7:0]       id_imm,
    output logic             halted,
    output logic [CNT_W-1:0] squash_count
);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [AW-1:0] id_npc;
    logic [AW-1:0] halt_pc;
    logic          id_load;
    logic          id_bubble;
    logic          halt_capture;
    logic          squash_inc;

    assign id_opcode = id_instruction[OPC_MSB:OPC_LSB];
    assign id_rd     = id_instruction[RD_MSB:RD_LSB];
    assign id_rs1    = id_instruction[RS1_MSB:RS1_LSB];
    assign id_rs2    = id_instruction[RS2_MSB:RS2_LSB];
    assign id_imm    = id_instruction[IMM_MSB:IMM_LSB];
    assign id_pc     = id_npc - AW'(1);
    assign halted    = (state == HALTED);

    // Steering depends only on registered state and stall_in, never on the
    // word fetch is presenting, so there is no combinational loop via fetch.
    always_comb begin
        state_nxt     = state;
        jump_selector = 1'b0;
        jump_address  = '0;
        id_load       = 1'b0;
        id_bubble     = 1'b0;
        halt_capture  = 1'b0;
        squash_inc    = 1'b0;
        case (state)
            BOOT: begin
                jump_selector = 1'b1;
                jump_address  = RESET_VECTOR;
                id_bubble     = 1'b1;
                state_nxt     = RUN;
            end
            RUN: begin
                if (id_valid && stall_in) begin
                    jump_selector = 1'b1;
                    jump_address  = id_npc;
                    squash_inc    = 1'b1;
                end else if (id_valid && (id_opcode == OP_JMP)) begin
                    jump_selector = 1'b1;
                    jump_address  = AW'(id_imm);
                    id_bubble     = 1'b1;
                    squash_inc    = 1'b1;
                end else if (id_valid && (id_opcode == OP_HALT)) begin
                    jump_selector = 1'b1;
                    jump_address  = id_pc;
                    halt_capture  = 1'b1;
                    id_bubble     = 1'b1;
                    squash_inc    = 1'b1;
                    state_nxt     = HALTED;
                end else begin
                    id_load = 1'b1;
                end
            end
            HALTED: begin
                jump_selector = 1'b1;
                jump_address  = halt_pc;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clkwire or posedge rstwire) begin
        if (rstwire) begin
            state          <= BOOT;
            id_valid       <= 1'b0;
            id_instruction <= '0;
            id_npc         <= '0;
            halt_pc        <= '0;
        end else begin
            state <= state_nxt;
            if (id_bubble) begin
                id_valid <= 1'b0;
            end else if (id_load) begin
                id_valid       <= 1'b1;
                id_instruction <= instructionwire;
                id_npc         <= npc;
            end
            if (halt_capture) begin
                halt_pc <= id_pc;
            end
        end
    end

    id_squash_counter #(
        .CNT_W(CNT_W)
    ) u_squash (
        .clkwire (clkwire),
        .rstwire (rstwire),
        .inc     (squash_inc),
        .count   (squash_count)
    );

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// Directed bench for id_fetch_ctrl driven by a simple fetch-unit model whose
// memory is reloaded per scenario.
module tb_id_fetch_ctrl;

    logic        clkwire = 1'b0;
    logic        rstwire = 1'b1;
    logic [19:0] instructionwire = '0;
    logic [7:0]  npc = '0;
    logic        stall_in = 1'b0;
    logic        jump_selector;
    logic [7:0]  jump_address;
    logic        id_valid;
    logic [19:0] id_instruction;
    logic [7:0]  id_pc;
    logic [3:0]  id_opcode, id_rd, id_rs1, id_rs2;
    logic [7:0]  id_imm;
    logic        halted;
    logic [15:0] squash_count;

    logic [19:0] mem [256];
    logic [7:0]  fetch_pc = '0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        stall;
        logic        exp_valid;
        logic [7:0]  exp_pc;
        logic        exp_js;
        logic [7:0]  exp_ja;
        logic        exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [19];

    id_fetch_ctrl dut (
        .clkwire         (clkwire),
        .rstwire         (rstwire),
        .instructionwire (instructionwire),
        .npc             (npc),
        .stall_in        (stall_in),
        .jump_selector   (jump_selector),
        .jump_address    (jump_address),
        .id_valid        (id_valid),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc),
        .id_opcode       (id_opcode),
        .id_rd           (id_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_imm          (id_imm),
        .halted          (halted),
        .squash_count    (squash_count)
    );

    always #5 clkwire = ~clkwire;

    // Fetch stand-in: each edge it fetches from the jump target or its own PC.
    always @(posedge clkwire) begin
        logic [7:0] a;
        a = jump_selector ? jump_address : fetch_pc;
        instructionwire <= mem[a];
        npc             <= a + 8'd1;
        fetch_pc        <= a + 8'd1;
    end

    function automatic vec_t mk(logic s, logic v, logic [7:0] pc, logic js,
                                logic [7:0] ja, logic h, logic [15:0] c);
        vec_t r;
        r.stall = s; r.exp_valid = v; r.exp_pc = pc; r.exp_js = js;
        r.exp_ja = ja; r.exp_halted = h; r.exp_cnt = c;
        return r;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        logic [19:0] ei;
        checkField({tag, ".id_valid"}, 32'(id_valid), 32'(v.exp_valid));
        checkField({tag, ".jump_selector"}, 32'(jump_selector), 32'(v.exp_js));
        checkField({tag, ".jump_address"}, 32'(jump_address), 32'(v.exp_ja));
        checkField({tag, ".halted"}, 32'(halted), 32'(v.exp_halted));
        checkField({tag, ".squash_count"}, 32'(squash_count), 32'(v.exp_cnt));
        if (v.exp_valid) begin
            ei = mem[v.exp_pc];
            checkField({tag, ".id_pc"}, 32'(id_pc), 32'(v.exp_pc));
            checkField({tag, ".id_instruction"}, 32'(id_instruction), 32'(ei));
            checkField({tag, ".id_opcode"}, 32'(id_opcode), 32'(ei[19:16]));
            checkField({tag, ".id_rd"}, 32'(id_rd), 32'(ei[15:12]));
            checkField({tag, ".id_rs1"}, 32'(id_rs1), 32'(ei[11:8]));
            checkField({tag, ".id_rs2"}, 32'(id_rs2), 32'(ei[7:4]));
            checkField({tag, ".id_imm"}, 32'(id_imm), 32'(ei[7:0]));
        end
    endtask

    task automatic applyStimulus(input logic s);
        stall_in = s;
        #1;
    endtask

    task automatic fillMem();
        for (int i = 0; i < 256; i++) mem[i] = 20'(i);
    endtask

    // Leaves the bench at a negedge with reset just released (BOOT cycle).
    task automatic resetDut(input string tag);
        rstwire  = 1'b1;
        stall_in = 1'b0;
        repeat (2) @(negedge clkwire);
        #1;
        checkOutput({tag, ".reset"}, mk(0, 0, 8'h00, 1, 8'h00, 0, 16'd0));
        rstwire = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0);
            @(negedge clkwire);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 8'h00, 1, 8'h00, 0, 16'd0);
        vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 16'd0);
        vecs[2]  = mk(0, 1, 8'h00, 0, 8'h00, 0, 16'd0);
        vecs[3]  = mk(0, 1, 8'h01, 0, 8'h00, 0, 16'd0);
        vecs[4]  = mk(1, 1, 8'h02, 1, 8'h03, 0, 16'd0);
        vecs[5]  = mk(1, 1, 8'h02, 1, 8'h03, 0, 16'd1);
        vecs[6]  = mk(1, 1, 8'h02, 1, 8'h03, 0, 16'd2);
        vecs[7]  = mk(0, 1, 8'h02, 0, 8'h00, 0, 16'd3);
        vecs[8]  = mk(0, 1, 8'h03, 0, 8'h00, 0, 16'd3);
        vecs[9]  = mk(0, 1, 8'h04, 0, 8'h00, 0, 16'd3);
        vecs[10] = mk(1, 1, 8'h05, 1, 8'h06, 0, 16'd3);
        vecs[11] = mk(0, 1, 8'h05, 1, 8'h30, 0, 16'd4);
        vecs[12] = mk(1, 0, 8'h00, 0, 8'h00, 0, 16'd5);
        vecs[13] = mk(0, 1, 8'h30, 0, 8'h00, 0, 16'd5);
        vecs[14] = mk(0, 1, 8'h31, 0, 8'h00, 0, 16'd5);
        vecs[15] = mk(0, 1, 8'h32, 1, 8'h32, 0, 16'd5);
        vecs[16] = mk(1, 0, 8'h00, 1, 8'h32, 1, 16'd6);
        vecs[17] = mk(0, 0, 8'h00, 1, 8'h32, 1, 16'd6);
        vecs[18] = mk(1, 0, 8'h00, 1, 8'h32, 1, 16'd6);

        // Boot, stall replay at 2, stalled JMP at 5 to 0x30, HALT at 0x32.
        fillMem();
        mem[8'h05] = 20'hE0030;
        mem[8'h32] = 20'hF0000;
        resetDut("main");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].stall);
            checkOutput($sformatf("main[%0d]", i), vecs[i]);
            @(negedge clkwire);
        end

        // HALT at address 7, then stall toggling must change nothing.
        fillMem();
        mem[8'h07] = 20'hF0000;
        resetDut("halt");
        runIdle(9);
        applyStimulus(1'b0);
        checkOutput("halt.id", mk(0, 1, 8'h07, 1, 8'h07, 0, 16'd0));
        @(negedge clkwire);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k[0]);
            checkOutput($sformatf("halt.park[%0d]", k), mk(k[0], 0, 8'h00, 1, 8'h07, 1, 16'd1));
            @(negedge clkwire);
        end

        // Jump to 0xFE and run across the PC wrap.
        fillMem();
        mem[8'h00] = 20'hE00FE;
        resetDut("wrap");
        runIdle(2);
        applyStimulus(1'b0);
        checkOutput("wrap.jmp", mk(0, 1, 8'h00, 1, 8'hFE, 0, 16'd0));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("wrap.bubble", mk(0, 0, 8'h00, 0, 8'h00, 0, 16'd1));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("wrap.fe", mk(0, 1, 8'hFE, 0, 8'h00, 0, 16'd1));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("wrap.ff", mk(0, 1, 8'hFF, 0, 8'h00, 0, 16'd1));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("wrap.00", mk(0, 1, 8'h00, 1, 8'hFE, 0, 16'd1));
        @(negedge clkwire);

        // Asynchronous reset between edges while a stall is being replayed.
        fillMem();
        resetDut("midrst");
        runIdle(4);
        applyStimulus(1'b1);
        checkOutput("midrst.stall0", mk(1, 1, 8'h02, 1, 8'h03, 0, 16'd0));
        @(negedge clkwire);
        applyStimulus(1'b1);
        checkOutput("midrst.stall1", mk(1, 1, 8'h02, 1, 8'h03, 0, 16'd1));
        #1;
        rstwire = 1'b1;
        #1;
        checkOutput("midrst.async", mk(1, 0, 8'h00, 1, 8'h00, 0, 16'd0));
        @(negedge clkwire);
        rstwire  = 1'b0;
        stall_in = 1'b0;
        applyStimulus(1'b0);
        checkOutput("midrst.boot", mk(0, 0, 8'h00, 1, 8'h00, 0, 16'd0));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("midrst.run", mk(0, 0, 8'h00, 0, 8'h00, 0, 16'd0));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("midrst.pc0", mk(0, 1, 8'h00, 0, 8'h00, 0, 16'd0));
        @(negedge clkwire);
        applyStimulus(1'b0);
        checkOutput("midrst.pc1", mk(0, 1, 8'h01, 0, 8'h00, 0, 16'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_fetch_ctrl.md
Name: id_fetch_ctrl

Overview:
- Decode-side partner of the fetch unit in the 5-stage pipeline. Consumes the fetch outputs (20-bit instruction, 8-bit next-PC) and registers them into the IF/ID stage.
- Fetch can only be steered through its jump inputs, so this block drives `jump_selector`/`jump_address` back to fetch. It uses them to boot fetch to a reset vector, take unconditional jumps, replay on stalls, and park on HALT.
- Its ID outputs feed decode/register-read.

Parameters:
- IW, 20, instruction width
- AW, 8, instruction address width
- RESET_VECTOR, 8'h00, first fetch address after reset
- CNT_W, 16, width of squash counter

Ports:
- clkwire  in  1  clock, all state on rising edge
- rstwire  in  1  reset, asynchronous, active-high
- instructionwire  in  IW  instruction from fetch (valid after each fetch edge)
- npc  in  AW  fetch PC after the edge (= address of instructionwire + 1)
- stall_in  in  1  hazard unit: hold current ID instruction
- jump_selector  out  1  steer fetch this edge
- jump_address  out  AW  fetch target when jump_selector=1
- id_valid  out  1  ID register holds a real instruction
- id_instruction  out  IW  registered instruction
- id_pc  out  AW  address of id_instruction (id_npc - 1, mod 2^AW)
- id_opcode / id_rd / id_rs1 / id_rs2  out  4 each  fields [19:16] / [15:12] / [11:8] / [7:4]
- id_imm  out  8  field [7:0]
- halted  out  1  HALT reached
- squash_count  out  CNT_W  fetched slots discarded, saturating

Behaviour:
- Registers: state {BOOT, RUN, HALTED}, id_valid, id_instruction, id_npc, halt_pc, squash_count. rstwire=1 asynchronously clears all to 0 and sets state=BOOT.
- Field outputs are combinational slices of id_instruction. id_pc = id_npc - 1; npc=8'h00 gives id_pc=8'hFF.
- jump_selector/jump_address are combinational from registered state plus stall_in only. There is no path from instructionwire or npc.
- While rstwire=1 (state BOOT): jump_selector=1, jump_address=RESET_VECTOR.
- BOOT, first edge after reset release:
  - ID←bubble (id_valid=0); incoming instruction discarded and not counted.
  - state→RUN.
- RUN, conditions evaluated in priority order each cycle:
  1. id_valid & stall_in:
     - ID held; incoming dropped.
     - jump_selector=1, jump_address=id_npc, so fetch re-fetches the instruction after the held one next cycle.
     - squash_count+1.
     - stall_in with id_valid=0 is ignored and treated as case 4.
  2. id_valid & id_opcode==OP_JMP (4'hE):
     - jump_selector=1, jump_address=id_imm.
     - ID←bubble (the wrong-path slot is dropped); squash_count+1.
     - Target instruction is latched on the following edge, a one-slot penalty.
  3. id_valid & id_opcode==OP_HALT (4'hF):
     - jump_selector=1, jump_address=id_pc.
     - halt_pc←id_pc; ID←bubble; squash_count+1; state→HALTED.
  4. Otherwise:
     - jump_selector=0, jump_address=8'h00.
     - ID←{1, instructionwire, npc}.
- HALTED:
  - jump_selector=1, jump_address=halt_pc; halted=1; id_valid=0.
  - stall_in ignored; counter frozen; exit only via rstwire.
- squash_count saturates at all-ones.
- JMP held under stall: stall wins. The JMP executes on the first unstalled cycle.
- JMP to its own address: legal, repeats forever with one bubble per iteration.
- Reset mid-stall or mid-jump: all state cleared immediately; BOOT steering resumes.
- Latency: instruction fetched at edge N appears on id_* after edge N+1.

Decomposition:
- Package if_id_pkg holds:
  - IW, AW
  - OP_JMP=4'hE, OP_HALT=4'hF
  - field bit positions
  - state enum {BOOT, RUN, HALTED}
- One natural sub-module: id_squash_counter (saturating CNT_W counter with increment enable and async reset).
- Everything else lives in the top.

Test Plan:
- Reset then release; fetch model memory[i]=i → first cycle jump_selector=1/addr 8'h00; id_valid=0; next edge id_pc=0; afterwards id_pc increments 0,1,2 with jump_selector=0.
- JMP 20'hE0030 at addr 5 → in ID cycle jump_selector=1, jump_address=8'h30; next cycle id_valid=0; then id_pc=8'h30; squash_count=1.
- stall_in=1 for 3 cycles with addr 2 in ID → id_instruction unchanged, jump_address=8'h03 each cycle; after release id_pc=3 (no lost or duplicate instruction); squash_count=3.
- HALT 20'hF0000 at addr 7 → halted=1; jump_address=8'h07 forever; id_valid=0; counter stops; stall_in toggling has no effect.
- Sequential run from 8'hFE → id_pc sequence FE, FF, 00 (npc wraps 8'hFF→8'h00).
- rstwire asserted mid-stall (asynchronous, between edges) → id_valid=0 and jump_address=RESET_VECTOR immediately; squash_count=0; normal boot after release.
